// File: rtl/operand_fetch_pipe_pkg.sv
// Shared RISC-V decode definitions: base opcodes, immediate formats and the
// decoded-bundle layout stored by the operand-fetch pipeline.
package riscv_pkg;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    // Major opcodes, instr[6:2]
    localparam logic [4:0] LOAD      = 5'b00000;
    localparam logic [4:0] MISC_MEM  = 5'b00011;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] AUIPC     = 5'b00101;
    localparam logic [4:0] OP_IMM_32 = 5'b00110;
    localparam logic [4:0] STORE     = 5'b01000;
    localparam logic [4:0] OP        = 5'b01100;
    localparam logic [4:0] LUI       = 5'b01101;
    localparam logic [4:0] OP_32     = 5'b01110;
    localparam logic [4:0] BRANCH    = 5'b11000;
    localparam logic [4:0] JALR      = 5'b11001;
    localparam logic [4:0] JAL       = 5'b11011;
    localparam logic [4:0] SYSTEM    = 5'b11100;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    // Width-independent part of a decoded entry; the XLEN-wide imm lives beside it
    typedef struct packed {
        logic [31:0] instr;
        imm_fmt_e    fmt;
        logic        rs1_en;
        logic        rs2_en;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/operand_fetch_pipe_imm_gen.sv
// Combinational immediate selector: picks the format from the major opcode,
// sign-extends the immediate to XLEN and derives the register read enables.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            rs1_en,
    output logic            rs2_en,
    output logic            illegal
);

    imm_fmt_e fmt_e;

    always_comb begin
        fmt_e   = FMT_I;
        illegal = 1'b0;
        case (instr[6:2])
            OP, OP_32:                                        fmt_e = FMT_R;
            OP_IMM, OP_IMM_32, LOAD, JALR, SYSTEM, MISC_MEM: fmt_e = FMT_I;
            STORE:                                            fmt_e = FMT_S;
            BRANCH:                                           fmt_e = FMT_B;
            LUI, AUIPC:                                       fmt_e = FMT_U;
            JAL:                                              fmt_e = FMT_J;
            default:                                          illegal = 1'b1;
        endcase
        // 16-bit compressed encodings are not part of the base set either
        if (instr[1:0] != 2'b11) illegal = 1'b1;
    end

    // Size casts of signed operands sign-extend from instr[31]
    always_comb begin
        imm = '0;
        if (!illegal) begin
            case (fmt_e)
                FMT_I:   imm = XLEN'($signed(instr[31:20]));
                FMT_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
                FMT_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
                FMT_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
                FMT_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
                default: imm = '0;
            endcase
        end
    end

    assign fmt    = fmt_e;
    assign rs1_en = !illegal && (fmt_e inside {FMT_R, FMT_I, FMT_S, FMT_B});
    assign rs2_en = !illegal && (fmt_e inside {FMT_R, FMT_S, FMT_B});

endmodule

// File: rtl/operand_fetch_pipe.sv
// Decode/operand-fetch stage: decodes on entry, then holds up to two entries
// (main drives the outputs, skid absorbs one beat of back-pressure).
module operand_fetch_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] pc_in,
    input  logic [31:0]     instr_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] pc_out,
    output logic [31:0]     instr_out,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_fmt,
    output logic            rs1_en,
    output logic            rs2_en,
    output logic            illegal
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("operand_fetch_pipe: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

    occ_e            state_q, state_d;
    logic            in_ready_q;
    logic            in_xfer, out_xfer;
    logic            load_main, load_skid, skid_to_main;
    dec_t            dec_in, main_q, main_d, skid_q, skid_d;
    logic [XLEN-1:0] imm_in, imm_main_q, imm_main_d, imm_skid_q, imm_skid_d;
    logic [PC_W-1:0] pc_main_q, pc_main_d, pc_skid_q, pc_skid_d;
    logic [2:0]      fmt_in;
    logic            rs1_en_in, rs2_en_in, illegal_in;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr   (instr_in),
        .imm     (imm_in),
        .fmt     (fmt_in),
        .rs1_en  (rs1_en_in),
        .rs2_en  (rs2_en_in),
        .illegal (illegal_in)
    );

    always_comb begin
        dec_in         = '0;
        dec_in.instr   = instr_in;
        dec_in.fmt     = imm_fmt_e'(fmt_in);
        dec_in.rs1_en  = rs1_en_in;
        dec_in.rs2_en  = rs2_en_in;
        dec_in.illegal = illegal_in;
    end

    // in_ready is the registered image of "next state is not TWO"
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    // A flush cycle never accepts input; halt blocks both transfers
    assign in_xfer  = in_valid && in_ready_q && !halt && !flush;
    assign out_xfer = out_valid && out_ready && !halt;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_xfer) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end else if (in_xfer) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end
                end
                TWO: if (out_xfer) begin
                    state_d      = ONE;
                    skid_to_main = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = in_ready_q;
    end

    always_comb begin
        main_d     = main_q;
        imm_main_d = imm_main_q;
        pc_main_d  = pc_main_q;
        skid_d     = skid_q;
        imm_skid_d = imm_skid_q;
        pc_skid_d  = pc_skid_q;
        if (skid_to_main) begin
            main_d     = skid_q;
            imm_main_d = imm_skid_q;
            pc_main_d  = pc_skid_q;
        end else if (load_main) begin
            main_d     = dec_in;
            imm_main_d = imm_in;
            pc_main_d  = pc_in;
        end
        if (load_skid) begin
            skid_d     = dec_in;
            imm_skid_d = imm_in;
            pc_skid_d  = pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            imm_main_q <= '0;
            pc_main_q  <= '0;
            skid_q     <= '0;
            imm_skid_q <= '0;
            pc_skid_q  <= '0;
        end else begin
            main_q     <= main_d;
            imm_main_q <= imm_main_d;
            pc_main_q  <= pc_main_d;
            skid_q     <= skid_d;
            imm_skid_q <= imm_skid_d;
            pc_skid_q  <= pc_skid_d;
        end
    end

    assign pc_out    = pc_main_q;
    assign instr_out = main_q.instr;
    assign rd        = main_q.instr[11:7];
    assign rs1       = main_q.instr[19:15];
    assign rs2       = main_q.instr[24:20];
    assign funct3    = main_q.instr[14:12];
    assign funct7    = main_q.instr[31:25];
    assign imm       = imm_main_q;
    assign imm_fmt   = main_q.fmt;
    assign rs1_en    = main_q.rs1_en;
    assign rs2_en    = main_q.rs2_en;
    assign illegal   = main_q.illegal;

endmodule

// File: doc/operand_fetch_pipe.md
# operand_fetch_pipe

Parametrised decode/operand-fetch pipeline stage sitting between instruction fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and extracts the rd/rs1/rs2/funct fields. It selects the single immediate the opcode needs, sign-extended to XLEN, and drives register-file read enables. A two-entry skid buffer gives full throughput under back-pressure, and it supports halt and flush.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- PC_W, XLEN, PC width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- halt  in  1  freezes the stage: no transfers on either side and all state is held.
- flush  in  1  discards all buffered instructions (branch/exception redirect).
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept; registered.
- pc_in  in  PC_W  PC of the incoming instruction.
- instr_in  in  32  incoming instruction word.
- out_valid  out  1  output bundle is valid.
- out_ready  in  1  downstream accepts.
- pc_out  out  PC_W  PC of the output instruction.
- instr_out  out  32  raw instruction word.
- rd, rs1, rs2  out  5 each  register fields.
- funct3  out  3  funct3 field.
- funct7  out  7  funct7 field.
- imm  out  XLEN  selected immediate, sign-extended.
- imm_fmt  out  3  imm_fmt_e value: R, I, S, B, U, J.
- rs1_en, rs2_en  out  1 each  register-file read enables.
- illegal  out  1  opcode is not in the RV32I/RV64I base set.

## Operation
- Transfers:
  - An input transfer happens when in_valid && in_ready && !halt.
  - An output transfer happens when out_valid && out_ready && !halt.
- Storage is a main register, which drives the outputs, and a skid register.
- Occupancy states: EMPTY, ONE (main full), TWO (main and skid full).
  - EMPTY to ONE on an input transfer.
  - ONE stays ONE on simultaneous input and output transfers: the new entry goes to main.
  - ONE to EMPTY on an output transfer only.
  - ONE to TWO on an input transfer with no output transfer: the new entry goes to skid.
  - TWO to ONE on an output transfer: skid moves to main.
  - TWO accepts no input.
- in_ready is 0 in state TWO and is recomputed at each edge; it is never combinationally dependent on out_ready.
- Decode is done before storage, so each stored entry already holds its fields, imm, fmt, enables and illegal.
- Immediate selection by opcode[6:2]:
  - OP, OP-32: R, imm = 0.
  - OP-IMM, OP-IMM-32, LOAD, JALR, SYSTEM, MISC-MEM: I.
  - STORE: S.
  - BRANCH: B.
  - LUI, AUIPC: U.
  - JAL: J.
  - Any other opcode: illegal = 1, fmt = I, imm = 0, both enables 0.
- Width rules: every immediate is sign-extended from instr[31] to XLEN. For XLEN = 64, U-type gives {{32{instr[31]}}, instr[31:12], 12'b0}.
- Enables:
  - rs1_en = 1 for R, I, S, B, except LUI/AUIPC/JAL, which have rs1_en = 0.
  - rs2_en = 1 for R, S, B.
- Priority: rst_n low, then flush, then halt, then normal operation.
- Flush: the next state is EMPTY and the input is not accepted in the flush cycle, even if in_valid is high. Flush wins over a simultaneous halt.
- Halt: out_valid keeps its value and the output bundle is stable. No entry is lost or duplicated.

## Timing
- Reset (rst_n low at an edge) gives, from the next cycle:
  - state EMPTY, out_valid = 0, in_ready = 1, illegal = 0.
  - all data outputs = 0: pc_out, instr_out, fields, imm, imm_fmt, enables.
- Latency: one cycle from an input transfer to out_valid, when the stage was EMPTY.
- Throughput: one instruction per cycle while out_ready = 1.
- in_ready falls the cycle after the second unconsumed entry is accepted. It rises the cycle after an output transfer in state TWO.
- out_valid and the bundle change only at clock edges. The bundle is held while out_valid && !out_ready.
- Reset asserted mid-operation discards all entries, exactly as a flush does, and loads the reset values.

## Structure
- Package riscv_pkg holds:
  - XLEN legal-value check.
  - opcode localparams: OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM.
  - imm_fmt_e enum, 3 bits.
  - a packed struct of the decoded bundle.
- Sub-module imm_gen: purely combinational, parametrised by XLEN, mapping instr to {imm, imm_fmt, rs1_en, rs2_en, illegal}.
- The top level holds the two bundle registers and the occupancy FSM.

## Test plan
- Reset then addi x1,x0,-1 (0xFFF00093) with out_ready = 1: one cycle later out_valid = 1, imm = 0xFFFFFFFF, fmt I, rd = 1, rs1_en = 1, rs2_en = 0.
- sw x2,4(x1) (0x0020A223), then beq x0,x0,-4 (0xFE000EE3) back to back:
  - first output: imm = 4, fmt S, rs1 = 1, rs2 = 2.
  - second output: imm = 0xFFFFFFFC, fmt B.
  - both enables = 1 for each.
- Back-pressure:
  - stimulus: out_ready = 0 for 3 cycles while 3 instructions are offered.
  - in_ready = 0 after the second accept and the third is stalled.
  - when out_ready = 1 again, the outputs appear in order, none dropped or duplicated.
- XLEN = 64, lui x5,0x80000 (0x800002B7): imm = 0xFFFFFFFF80000000, fmt U, rs1_en = 0.
- State TWO with flush = 1 and in_valid = 1 in the same cycle: next cycle out_valid = 0 and in_ready = 1, and the offered instruction is not captured.
- Halt:
  - holding halt for 4 cycles in state ONE with out_ready = 1 keeps the bundle stable, with no transfers.
  - a mid-stream rst_n = 0 gives all outputs 0 and out_valid = 0 the next cycle.
  - an undefined opcode 0x0000007F gives illegal = 1 and imm = 0.
